// File: rtl/avalon_mem_pkg.sv
// Shared widths and FSM state type for the Avalon-MM memory responder.
package avalon_mem_pkg;

  localparam int AV_DATA_W  = 32;
  localparam int AV_ADDR_W  = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    GRANT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/avalon_mem_responder_read_return_pipe.sv
// Fixed-latency return path for granted reads: a DEPTH-stage shift register
// of {valid,data}, cleared synchronously so in-flight reads vanish on reset.
module read_return_pipe
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = AV_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      // Data is zeroed on entry so empty slots never carry stale words.
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave RAM with programmable waitrequest stall, fixed read latency
// and an outstanding-read bound. Define AVALON_MEM_PROTOCOL_CHECK_EN to build
// the sticky protocol_error checker; otherwise protocol_error is tied low.
//
// state | meaning
// IDLE  | waitrequest high, waiting for a command
// STALL | waitrequest high, counting wait cycles / waiting for a pending slot
// GRANT | waitrequest low, the command on the bus this cycle is accepted
module avalon_mem_responder
  import avalon_mem_pkg::*;
#(
  parameter int ADDR_WORDS   = 1024,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AV_ADDR_W-1:0] slave_address,
  input  logic                 slave_read,
  input  logic                 slave_write,
  input  logic [AV_DATA_W-1:0] slave_writedata,
  output logic                 slave_waitrequest,
  output logic [AV_DATA_W-1:0] slave_readdata,
  output logic                 slave_readdatavalid,
  output logic                 protocol_error
);

  localparam int IDX_W  = $clog2(ADDR_WORDS);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [PEND_W-1:0]     PEND_MAX  = PEND_W'(MAX_PENDING);

  mem_state_t            r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [PEND_W-1:0]     r_pending;
  logic                  r_waitrequest;
  logic                  r_readdatavalid;
  logic [AV_DATA_W-1:0]  r_readdata;
  logic [AV_DATA_W-1:0]  r_mem [ADDR_WORDS];

  logic                  w_req;
  logic                  w_grant;
  logic                  w_wr_grant;
  logic                  w_rd_grant;
  logic                  w_can_grant;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_pipe_valid;
  logic [AV_DATA_W-1:0]  w_pipe_data;
  logic                  w_unused_addr;

  assign w_req       = slave_read | slave_write;
  assign w_idx       = slave_address[2 +: IDX_W];
  assign w_grant     = (r_state == GRANT) && w_req;
  assign w_wr_grant  = w_grant && slave_write;
  assign w_rd_grant  = w_grant && slave_read && !slave_write;
  assign w_can_grant = (r_pending < PEND_MAX);
  assign w_unused_addr = ^{slave_address[1:0], slave_address[AV_ADDR_W-1:IDX_W+2]};

  // STALL lasts WAIT_CYCLES cycles: the grant decision is taken when cnt<=1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_waitrequest <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if ((WAIT_CYCLES == 0) && w_can_grant) begin
              r_state       <= GRANT;
              r_waitrequest <= 1'b0;
            end else begin
              r_state <= STALL;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        STALL: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_cnt > WAIT_CNT_W'(1)) begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end else begin
            r_cnt <= '0;
            if (w_can_grant) begin
              r_state       <= GRANT;
              r_waitrequest <= 1'b0;
            end
          end
        end
        GRANT: begin
          r_state       <= IDLE;
          r_waitrequest <= 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          r_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      case ({w_rd_grant, r_readdatavalid})
        2'b10:   r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // RAM contents survive reset; a write granted while reset is low is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_grant) r_mem[w_idx] <= slave_writedata;
  end

  read_return_pipe #(
    .DEPTH  (READ_LATENCY),
    .DATA_W (AV_DATA_W)
  ) u_read_return_pipe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (w_rd_grant),
    .i_data  (r_mem[w_idx]),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_readdatavalid <= 1'b0;
      r_readdata      <= '0;
    end else begin
      r_readdatavalid <= w_pipe_valid;
      r_readdata      <= w_pipe_valid ? w_pipe_data : '0;
    end
  end

  assign slave_waitrequest   = r_waitrequest;
  assign slave_readdatavalid = r_readdatavalid;
  assign slave_readdata      = r_readdata;

`ifdef AVALON_MEM_PROTOCOL_CHECK_EN
  logic                 r_protocol_error;
  logic                 r_prev_stall;
  logic                 r_prev_write;
  logic [AV_ADDR_W-1:0] r_prev_addr;
  logic [AV_DATA_W-1:0] r_prev_wdata;
  logic                 w_cmd_changed;
  logic                 w_violation;

  // The command must hold steady from one STALL cycle into the next STALL/GRANT.
  assign w_cmd_changed = r_prev_stall && w_req &&
                         ((r_state == STALL) || (r_state == GRANT)) &&
                         ((slave_address != r_prev_addr) ||
                          (slave_write != r_prev_write) ||
                          (slave_writedata != r_prev_wdata));
  assign w_violation = (slave_read && slave_write) ||
                       ((r_state == STALL) && !w_req) ||
                       w_cmd_changed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_protocol_error <= 1'b0;
      r_prev_stall     <= 1'b0;
      r_prev_write     <= 1'b0;
      r_prev_addr      <= '0;
      r_prev_wdata     <= '0;
    end else begin
      if (w_violation) r_protocol_error <= 1'b1;
      r_prev_stall <= (r_state == STALL) && w_req;
      r_prev_write <= slave_write;
      r_prev_addr  <= slave_address;
      r_prev_wdata <= slave_writedata;
    end
  end

  assign protocol_error = r_protocol_error;
`else
  assign protocol_error = 1'b0;
`endif

endmodule
